// File: rtl/kernel_coeff_editor.sv
// 3x3 signed convolution-kernel editor: push-button cursor, switch writes, 7-seg readout.
// Optional macro KERNEL_SUM_EN builds the saturated coefficient-sum output.
module kernel_coeff_editor #(
    parameter int unsigned PRECISION = 16
) (
    input  logic                                VGA_CLK,
    input  logic                                reset,
    input  logic [1:0]                          KEY,
    input  logic [8:0]                          SW,
    output logic [6:0]                          HEX1,
    output logic [6:0]                          HEX2,
    output logic [6:0]                          HEX4,
    output logic [6:0]                          HEX5,
    output logic [2:0][2:0][PRECISION-1:0]      custom_kernel,
    output logic [7:0]                          kernel_sum_u8
);

    localparam int unsigned SUM_W = PRECISION + 4;

    logic [1:0]           key_s1, key_s2, key_prev;
    logic [1:0]           pressed;
    logic [1:0]           x, y;
    logic [3:0]           val_q;
    logic                 wr_q;
    logic [PRECISION-1:0] sel_q;
    logic                 sel_neg;
    logic [3:0]           sel_mag;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Synchronise the async keys; a pulse marks each high-to-low transition.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            key_s1   <= 2'b11;
            key_s2   <= 2'b11;
            key_prev <= 2'b11;
        end else begin
            key_s1   <= KEY;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign pressed = key_prev & ~key_s2;

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            x <= 2'd0;
            y <= 2'd0;
        end else begin
            if (pressed[0]) x <= (x == 2'd2) ? 2'd0 : x + 2'd1;
            if (pressed[1]) y <= (y == 2'd2) ? 2'd0 : y + 2'd1;
        end
    end

    // Write uses the cursor as it stands this cycle; moves land on the next write.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            val_q         <= 4'd0;
            wr_q          <= 1'b0;
            custom_kernel <= {9{PRECISION'(1)}};
            sel_q         <= PRECISION'(1);
        end else begin
            val_q <= SW[7:4];
            wr_q  <= SW[8];
            if (wr_q) custom_kernel[y][x] <= PRECISION'($signed(val_q));
            sel_q <= custom_kernel[y][x];
        end
    end

    assign sel_neg = sel_q[PRECISION-1];
    assign sel_mag = sel_neg ? 4'(~sel_q[3:0] + 4'd1) : sel_q[3:0];

    assign HEX1 = seg7({2'b00, y});
    assign HEX2 = seg7({2'b00, x});
    assign HEX4 = seg7(sel_mag);
    assign HEX5 = sel_neg ? 7'b0111111 : 7'b1111111;

`ifdef KERNEL_SUM_EN
    logic signed [SUM_W-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum_c = sum_c + SUM_W'($signed(custom_kernel[2'(i)][2'(j)]));
            end
        end
    end

    // Clamp to 0..255 so the normalisation aid never wraps.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            kernel_sum_u8 <= 8'd9;
        end else if (sum_c[SUM_W-1]) begin
            kernel_sum_u8 <= 8'd0;
        end else if (sum_c > $signed(SUM_W'(255))) begin
            kernel_sum_u8 <= 8'd255;
        end else begin
            kernel_sum_u8 <= sum_c[7:0];
        end
    end
`else
    assign kernel_sum_u8 = 8'd0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, SW[3:0], sel_q[PRECISION-2:4]};

endmodule

// File: tb/tb_kernel_coeff_editor.sv
// Directed self-checking bench for kernel_coeff_editor.
module tb_kernel_coeff_editor;

    logic                       VGA_CLK;
    logic                       reset;
    logic [1:0]                 KEY;
    logic [8:0]                 SW;
    logic [6:0]                 HEX1, HEX2, HEX4, HEX5;
    logic [2:0][2:0][15:0]      custom_kernel;
    logic [7:0]                 kernel_sum_u8;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] SEG_0  = 7'b1000000;
    localparam logic [6:0] SEG_1  = 7'b1111001;
    localparam logic [6:0] SEG_2  = 7'b0100100;
    localparam logic [6:0] SEG_3  = 7'b0110000;
    localparam logic [6:0] SEG_7  = 7'b1111000;
    localparam logic [6:0] SEG_8  = 7'b0000000;
    localparam logic [6:0] MINUS  = 7'b0111111;
    localparam logic [6:0] BLANK  = 7'b1111111;

`ifdef KERNEL_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    kernel_coeff_editor #(.PRECISION(16)) dut (
        .VGA_CLK       (VGA_CLK),
        .reset         (reset),
        .KEY           (KEY),
        .SW            (SW),
        .HEX1          (HEX1),
        .HEX2          (HEX2),
        .HEX4          (HEX4),
        .HEX5          (HEX5),
        .custom_kernel (custom_kernel),
        .kernel_sum_u8 (kernel_sum_u8)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge VGA_CLK);
        #1;
    endtask

    task automatic press(input int k);
        KEY[k] = 1'b0;
        tick(3);
        KEY[k] = 1'b1;
        tick(3);
    endtask

    task automatic write_val(input logic [3:0] v);
        SW = {1'b1, v, 4'b0000};
        tick(3);
        SW = 9'd0;
        tick(3);
    endtask

    task automatic check_all(input string tag, input logic [15:0] exp);
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 3; xx++)
                check($sformatf("%s[%0d][%0d]", tag, yy, xx), 32'(custom_kernel[yy][xx]), 32'(exp));
    endtask

    function automatic logic [7:0] exp_sum(input logic [7:0] v);
        return SUM_ON ? v : 8'd0;
    endfunction

    initial begin
        reset = 1'b1;
        KEY   = 2'b11;
        SW    = 9'd0;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state
        check_all("rst_cell", 16'd1);
        check("rst_hex1", 32'(HEX1), 32'(SEG_0));
        check("rst_hex2", 32'(HEX2), 32'(SEG_0));
        check("rst_hex4", 32'(HEX4), 32'(SEG_1));
        check("rst_hex5", 32'(HEX5), 32'(BLANK));
        check("rst_sum", 32'(kernel_sum_u8), 32'(exp_sum(8'd9)));

        // Held key advances exactly once
        KEY[0] = 1'b0;
        tick(10);
        KEY[0] = 1'b1;
        tick(4);
        check("held_x1", 32'(HEX2), 32'(SEG_1));
        press(0);
        check("x2", 32'(HEX2), 32'(SEG_2));
        press(0);
        check("x_wrap", 32'(HEX2), 32'(SEG_0));

        // Negative write at (1,1)
        press(1);
        check("y1", 32'(HEX1), 32'(SEG_1));
        press(0);
        check("x1", 32'(HEX2), 32'(SEG_1));
        SW = 9'b1_1101_0000;
        tick(3);
        SW = 9'd0;
        tick(3);
        check("neg_cell", 32'(custom_kernel[1][1]), 32'h0000_FFFD);
        check("neg_c00", 32'(custom_kernel[0][0]), 32'd1);
        check("neg_c12", 32'(custom_kernel[1][2]), 32'd1);
        check("neg_c21", 32'(custom_kernel[2][1]), 32'd1);
        check("neg_hex5", 32'(HEX5), 32'(MINUS));
        check("neg_hex4", 32'(HEX4), 32'(SEG_3));
        check("neg_sum", 32'(kernel_sum_u8), 32'(exp_sum(8'd5)));

        // Most negative nibble
        write_val(4'b1000);
        check("m8_cell", 32'(custom_kernel[1][1]), 32'h0000_FFF8);
        check("m8_hex4", 32'(HEX4), 32'(SEG_8));
        check("m8_hex5", 32'(HEX5), 32'(MINUS));
        check("m8_sum", 32'(kernel_sum_u8), 32'(exp_sum(8'd0)));

        // Fill every cell with -1: sum clamps to 0
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                write_val(4'hF);
                press(0);
            end
            press(1);
        end
        check_all("neg1_cell", 16'hFFFF);
        check("neg1_sum", 32'(kernel_sum_u8), 32'(exp_sum(8'd0)));
        check("neg1_hex4", 32'(HEX4), 32'(SEG_1));

        // Fill every cell with 7: sum 63
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                write_val(4'h7);
                press(0);
            end
            press(1);
        end
        check_all("p7_cell", 16'd7);
        check("p7_sum", 32'(kernel_sum_u8), 32'(exp_sum(8'd63)));
        check("p7_hex4", 32'(HEX4), 32'(SEG_7));
        check("p7_hex5", 32'(HEX5), 32'(BLANK));

        // Simultaneous row and column presses from (1,1)
        KEY = 2'b00;
        tick(3);
        KEY = 2'b11;
        tick(3);
        check("both_x", 32'(HEX2), 32'(SEG_2));
        check("both_y", 32'(HEX1), 32'(SEG_2));

        // Reset in the middle of a write
        SW = 9'b1_0011_0000;
        tick(2);
        reset = 1'b1;
        #1;
        check_all("rstw_cell", 16'd1);
        check("rstw_hex2", 32'(HEX2), 32'(SEG_0));
        SW = 9'd0;
        tick(2);
        reset = 1'b0;
        tick(4);
        check_all("post_cell", 16'd1);
        check("post_sum", 32'(kernel_sum_u8), 32'(exp_sum(8'd9)));

        // First press after reset is detected
        press(0);
        check("post_press", 32'(HEX2), 32'(SEG_1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_coeff_editor.md
# kernel_coeff_editor

User-facing editor for a 3x3 signed convolution kernel. Two push-buttons select the row and column cursor, switches supply a signed 4-bit value and a write enable, and four seven-segment displays show the cursor position and the signed coefficient under it. The block feeds the mutable-kernel convolution datapath in the VGA filter pipeline. It also reports the kernel's coefficient sum, saturated to 8 bits, as a normalisation aid.

## Interface
- PRECISION, 16, width of each stored coefficient (signed, two's complement), ≥ 8.
- VGA_CLK  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- KEY  in  2  active-low push-buttons, asynchronous to VGA_CLK. KEY[0] advances the column (x); KEY[1] advances the row (y).
- SW  in  9  SW[7:4] is the signed 4-bit value; SW[8] is write enable; SW[3:0] is unused.
- HEX1  out  7  y digit, active-low segments.
- HEX2  out  7  x digit, active-low segments.
- HEX4  out  7  magnitude of the selected coefficient.
- HEX5  out  7  sign of the selected coefficient.
- custom_kernel  out  [2:0][2:0] x PRECISION  coefficient array, indexed [y][x], signed.
- kernel_sum_u8  out  8  saturated sum of all nine coefficients.

## Operation
- **Button front end (per key)**
  - Two-flop synchroniser (s1 → s2), followed by a prev flop.
  - `pressed = prev & ~s2`: a one-cycle pulse per high-to-low transition.
  - Holding the key produces no further pulses; reset clears s1, s2 and prev to 1.
- **Cursor**
  - A column pulse sets x ← (x == 2) ? 0 : x + 1. A row pulse does the same for y.
  - x and y each take only the values 0..2.
  - Simultaneous column and row pulses both apply in the same cycle.
- **Write path**
  - Registers: `val_q ← SW[7:4]`, `wr_q ← SW[8]`.
  - While `wr_q == 1`, each cycle performs `custom_kernel[y][x] ← sign-extend(val_q)` to PRECISION bits.
  - The write uses the current x and y. A cursor move in the same cycle takes effect for the following cycle's write.
- **Display**
  - `sel_q ← custom_kernel[y][x]`, registered.
  - HEX5 = 7'b0111111 (minus) when sel_q < 0, otherwise 7'b1111111 (blank).
  - HEX4 = hex digit of |sel_q[3:0]|, so −8 displays "8".
  - HEX2 and HEX1 show x and y as digits.
- **Seven-segment decode**
  - Combinational, bit order {g,f,e,d,c,b,a}, 0 = segment lit.
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- **Sum saturation**
  - Signed sum of the nine coefficients, computed at PRECISION + 4 bits.
  - Result < 0 gives 0; result > 255 gives 255; otherwise the low 8 bits. The output is registered.
- **Reset values**
  - All coefficients = 1; x = y = 0; wr_q = 0; val_q = 0; sel_q = 1.
  - kernel_sum_u8 = 9.
  - HEX1 = HEX2 = "0", HEX4 = "1", HEX5 = blank.

## Timing
- **Button to cursor:** the edge that first samples KEY low is edge 0. The pulse is high between edges 1 and 2, and x/y updates on edge 2. A press shorter than two cycles may be missed; no debounce beyond the synchroniser.
- **Switch to coefficient:** SW sampled at edge 0; the coefficient is updated at edge 1; sel_q reflects it at edge 2. HEX4/HEX5 follow combinationally from sel_q.
- **Cursor to display:** after a cursor change at edge n, HEX1/HEX2 change immediately and sel_q updates at edge n+1.
- **Sum:** kernel_sum_u8 reflects the coefficient array one edge after it changes.
- **Reset:** asserting reset mid-operation clears all state immediately, including an in-flight write or pulse. The first press after release is detected normally.

## Configuration
- KERNEL_SUM_EN
  - Defined: the sum adder tree and saturation register are built, and kernel_sum_u8 behaves as specified.
  - Undefined: no adder is built and kernel_sum_u8 is held at 8'd0, including during reset.

## Test plan
- **Reset:** assert reset for 2 cycles → every coefficient = 1, HEX1 = HEX2 = 1000000, HEX4 = 1111001, HEX5 = 1111111, kernel_sum_u8 = 9 (0 without KERNEL_SUM_EN).
- **Held key:** hold KEY[0] low for 10 cycles, then release → x = 1 exactly, HEX2 = 1111001. Two more presses → x wraps to 0.
- **Negative write:** press KEY[1] once (y = 1), press KEY[0] once (x = 1), set SW = 9'b1_1101_0000 for 3 cycles → custom_kernel[1][1] = −3 (16'hFFFD), HEX5 = 0111111, HEX4 = 0110000 ("3"); the other eight cells stay 1.
- **Edge value:** write SW[7:4] = 4'b1000 → the cell reads −8, HEX4 = 0000000 ("8"), HEX5 shows minus.
- **Sum saturation:** write −1 into all nine cells → kernel_sum_u8 = 0. Write 7 into all nine cells → kernel_sum_u8 = 63.
- **Reset mid-write:** assert reset while SW[8] = 1 → coefficients return to 1 at once; after release with SW[8] = 0 they remain 1.
